// File: rtl/ol_walker_if.sv
// Walker-side VRAM read port and isp_parser handshake bundled as one interface.
// The master modport is the walker; the slave modport is the memory/parser side.
interface ol_walker_if;
  logic        ol_vram_rd;
  logic [23:0] ol_vram_addr;
  logic [31:0] ol_vram_din;
  logic [23:0] poly_addr;
  logic        render_poly;
  logic        poly_drawn;
  logic [1:0]  prim_type;
  logic        shadow;
  logic [2:0]  skip;
  logic [5:0]  strip_mask;

  modport master (
    output ol_vram_rd,
    output ol_vram_addr,
    input  ol_vram_din,
    output poly_addr,
    output render_poly,
    input  poly_drawn,
    output prim_type,
    output shadow,
    output skip,
    output strip_mask
  );

  modport slave (
    input  ol_vram_rd,
    input  ol_vram_addr,
    output ol_vram_din,
    input  poly_addr,
    input  render_poly,
    output poly_drawn,
    input  prim_type,
    input  shadow,
    input  skip,
    input  strip_mask
  );
endinterface

// File: rtl/ol_walker.sv
// Object-list walker: fetches list words from VRAM, follows links and issues one
// render_poly per primitive to isp_parser, waiting for poly_drawn between primitives.
module ol_walker #(
  parameter int MAX_ENTRIES = 4096
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        start,
  input  logic [23:0] ol_addr,
  input  logic [23:0] param_base,
  ol_walker_if.master bus,
  output logic        busy,
  output logic        done,
  output logic        overflow
);

  localparam logic [2:0] IDLE       = 3'd0;
  localparam logic [2:0] FETCH      = 3'd1;
  localparam logic [2:0] DECODE     = 3'd2;
  localparam logic [2:0] ISSUE      = 3'd3;
  localparam logic [2:0] WAIT_DRAWN = 3'd4;
  localparam logic [2:0] DONE       = 3'd5;

  localparam int               CNT_W   = $clog2(MAX_ENTRIES + 1);
  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_ENTRIES);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [2:0]       state_r;
  logic             rd_r;
  logic [23:0]      vram_addr_r;
  logic [23:0]      poly_addr_r;
  logic             render_r;
  logic [1:0]       prim_type_r;
  logic             shadow_r;
  logic [2:0]       skip_r;
  logic [5:0]       strip_mask_r;
  logic             busy_r;
  logic             done_r;
  logic             overflow_r;
  logic [CNT_W-1:0] fetch_cnt_r;
  logic [4:0]       prim_rem_r;
  logic [23:0]      param_base_r;

  logic [31:0]      word_s;
  logic [CNT_W-1:0] cnt_inc_s;
  logic             is_link_s;
  logic             is_rsvd_s;
  logic [1:0]       dec_type_s;
  logic [5:0]       dec_mask_s;
  logic [4:0]       dec_count_s;
  logic [23:0]      dec_poly_s;
  logic [23:0]      stride_s;

  // Byte distance between consecutive primitives of an array entry.
  function automatic logic [23:0] prim_stride(input logic [1:0] ptype, input logic [2:0] skp);
    logic [7:0] vw;
    logic [7:0] words;
    vw = 8'd3 + {5'd0, skp};
    case (ptype)
      2'd1:    words = 8'd3 + (vw + {vw[6:0], 1'b0});
      2'd2:    words = 8'd3 + {vw[5:0], 2'b00};
      default: words = 8'd0;
    endcase
    return {14'd0, words, 2'b00};
  endfunction

  // Decode of the word returned by the preceding FETCH.
  always_comb begin
    word_s      = bus.ol_vram_din;
    cnt_inc_s   = fetch_cnt_r + CNT_ONE;
    is_link_s   = (word_s[31:29] == 3'b111);
    is_rsvd_s   = (word_s[31:29] == 3'b110);
    dec_poly_s  = param_base_r + {1'b0, word_s[20:0], 2'b00};
    dec_type_s  = 2'd0;
    dec_mask_s  = 6'd0;
    dec_count_s = 5'd1;
    case (word_s[31:29])
      3'b100: begin
        dec_type_s  = 2'd1;
        dec_count_s = {1'b0, word_s[28:25]} + 5'd1;
      end
      3'b101: begin
        dec_type_s  = 2'd2;
        dec_count_s = {1'b0, word_s[28:25]} + 5'd1;
      end
      default: dec_mask_s = word_s[30:25];
    endcase
    stride_s = prim_stride(prim_type_r, skip_r);
  end

  // Walk sequencer; strobes default low and are raised on entry to their state.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_r      <= IDLE;
      rd_r         <= 1'b0;
      vram_addr_r  <= 24'd0;
      poly_addr_r  <= 24'd0;
      render_r     <= 1'b0;
      prim_type_r  <= 2'd0;
      shadow_r     <= 1'b0;
      skip_r       <= 3'd0;
      strip_mask_r <= 6'd0;
      busy_r       <= 1'b0;
      done_r       <= 1'b0;
      overflow_r   <= 1'b0;
      fetch_cnt_r  <= {CNT_W{1'b0}};
      prim_rem_r   <= 5'd0;
      param_base_r <= 24'd0;
    end else begin
      rd_r     <= 1'b0;
      render_r <= 1'b0;
      done_r   <= 1'b0;
      case (state_r)
        IDLE: begin
          if (start) begin
            vram_addr_r  <= ol_addr & 24'hFF_FFFC;
            param_base_r <= param_base;
            overflow_r   <= 1'b0;
            busy_r       <= 1'b1;
            fetch_cnt_r  <= {CNT_W{1'b0}};
            rd_r         <= 1'b1;
            state_r      <= FETCH;
          end
        end
        FETCH: state_r <= DECODE;
        DECODE: begin
          fetch_cnt_r <= cnt_inc_s;
          if (cnt_inc_s >= MAX_CNT) begin
            overflow_r <= 1'b1;
            done_r     <= 1'b1;
            state_r    <= DONE;
          end else if (is_link_s && word_s[28]) begin
            done_r  <= 1'b1;
            state_r <= DONE;
          end else if (is_link_s) begin
            vram_addr_r <= {word_s[23:2], 2'b00};
            rd_r        <= 1'b1;
            state_r     <= FETCH;
          end else if (is_rsvd_s) begin
            vram_addr_r <= vram_addr_r + 24'd4;
            rd_r        <= 1'b1;
            state_r     <= FETCH;
          end else begin
            poly_addr_r  <= dec_poly_s;
            prim_type_r  <= dec_type_s;
            shadow_r     <= word_s[24];
            skip_r       <= word_s[23:21];
            strip_mask_r <= dec_mask_s;
            prim_rem_r   <= dec_count_s;
            render_r     <= 1'b1;
            state_r      <= ISSUE;
          end
        end
        // A poly_drawn coinciding with render_poly is deliberately not looked at here.
        ISSUE: state_r <= WAIT_DRAWN;
        WAIT_DRAWN: begin
          if (bus.poly_drawn) begin
            prim_rem_r <= prim_rem_r - 5'd1;
            if (prim_rem_r != 5'd1) begin
              poly_addr_r <= poly_addr_r + stride_s;
              render_r    <= 1'b1;
              state_r     <= ISSUE;
            end else begin
              vram_addr_r <= vram_addr_r + 24'd4;
              rd_r        <= 1'b1;
              state_r     <= FETCH;
            end
          end
        end
        DONE: begin
          busy_r  <= 1'b0;
          state_r <= IDLE;
        end
        default: state_r <= IDLE;
      endcase
    end
  end

  assign bus.ol_vram_rd   = rd_r;
  assign bus.ol_vram_addr = vram_addr_r;
  assign bus.poly_addr    = poly_addr_r;
  assign bus.render_poly  = render_r;
  assign bus.prim_type    = prim_type_r;
  assign bus.shadow       = shadow_r;
  assign bus.skip         = skip_r;
  assign bus.strip_mask   = strip_mask_r;
  assign busy             = busy_r;
  assign done             = done_r;
  assign overflow         = overflow_r;

endmodule

// File: tb/tb_ol_walker.sv
// Self-checking bench for ol_walker: decode vector table, hand-written corner
// sequences, and random lists compared against a list-walking reference model.
module tb_ol_walker;
  localparam int MAXE = 4;

  typedef struct packed {
    logic [23:0] addr;
    logic [1:0]  ptype;
    logic        sh;
    logic [2:0]  sk;
    logic [5:0]  mask;
  } rend_t;

  typedef struct {
    logic [31:0] word;
    logic [23:0] pbase;
    logic [23:0] exp_addr;
    logic [1:0]  exp_type;
    logic        exp_sh;
    logic [2:0]  exp_sk;
    logic [5:0]  exp_mask;
    int          exp_n;
  } vec_t;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        start;
  logic [23:0] ol_addr;
  logic [23:0] param_base;
  logic        busy, done, overflow;
  logic        drawn_auto = 1'b0;
  logic        drawn_man;
  logic        auto_en;
  int          pend = 0;

  ol_walker_if bus();
  assign bus.poly_drawn = drawn_auto | drawn_man;

  ol_walker #(.MAX_ENTRIES(MAXE)) dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .start      (start),
    .ol_addr    (ol_addr),
    .param_base (param_base),
    .bus        (bus),
    .busy       (busy),
    .done       (done),
    .overflow   (overflow)
  );

  always #5 clock = ~clock;

  // VRAM model: one-cycle read latency, 4 KB window.
  logic [31:0] mem [0:1023];
  always @(posedge clock)
    bus.ol_vram_din <= bus.ol_vram_rd ? mem[bus.ol_vram_addr[11:2]] : 32'h0;

  // isp_parser model: answers each render_poly after a random 1..4 cycles.
  always @(posedge clock) begin
    drawn_auto <= 1'b0;
    if (!reset_n) pend <= 0;
    else if (bus.render_poly && auto_en) pend <= int'($urandom_range(1, 4));
    else if (pend > 1) pend <= pend - 1;
    else if (pend == 1) begin
      drawn_auto <= 1'b1;
      pend       <= 0;
    end
  end

  logic [23:0] got_rd[$];
  rend_t       got_rend[$];
  int          done_cnt = 0, cyc = 0, last_rd_cyc = 0, done_cyc = 0, viol = 0;
  logic        outstanding = 1'b0;
  logic        done_ovf = 1'b0;

  // Observer, sampling each cycle just after the clock edge.
  always @(posedge clock) begin
    #1;
    cyc++;
    if (reset_n) begin
      if (bus.ol_vram_rd) begin
        got_rd.push_back(bus.ol_vram_addr);
        last_rd_cyc = cyc;
      end
      if (bus.render_poly) begin
        if (outstanding) viol++;
        outstanding = 1'b1;
        got_rend.push_back({bus.poly_addr, bus.prim_type, bus.shadow, bus.skip, bus.strip_mask});
      end else if (bus.poly_drawn && outstanding) begin
        outstanding = 1'b0;
      end
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
        done_ovf = overflow;
      end
    end else begin
      outstanding = 1'b0;
    end
  end

  int errors = 0, checks = 0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic clear_obs();
    got_rd.delete();
    got_rend.delete();
    done_cnt = 0;
  endtask

  task automatic do_start(input logic [23:0] a, input logic [23:0] pb);
    @(negedge clock);
    ol_addr    = a;
    param_base = pb;
    start      = 1'b1;
    @(negedge clock);
    start      = 1'b0;
  endtask

  // Waits for done within a budget; optionally pulses a stray start while busy.
  task automatic wait_done(input string name, input int inject_at);
    int n;
    n = 0;
    while (done_cnt == 0 && n < 3000) begin
      @(negedge clock);
      n++;
      if (n == inject_at && busy) begin
        start   = 1'b1;
        ol_addr = 24'(($urandom & 32'h00FF_FFFF));
        @(negedge clock);
        start   = 1'b0;
      end
    end
    check({name, "_done_seen"}, 64'(done_cnt != 0), 64'd1);
    tick(3);
  endtask

  task automatic wait_render(input string name, input int cnt);
    int n;
    n = 0;
    while (got_rend.size() < cnt && n < 500) begin
      @(negedge clock);
      n++;
    end
    check({name, "_render_seen"}, 64'(got_rend.size() >= cnt), 64'd1);
  endtask

  logic [23:0] exp_rd[$];
  rend_t       exp_rend[$];
  logic        exp_ovf;

  // Reference walk: follows the list in memory using the entry encoding rules.
  task automatic model_walk(input logic [23:0] ol, input logic [23:0] pb);
    logic [23:0] a;
    logic [31:0] w, pa;
    int n, cnt, vw, stride;
    exp_rd.delete();
    exp_rend.delete();
    exp_ovf = 1'b0;
    a = ol & 24'hFF_FFFC;
    n = 0;
    forever begin
      exp_rd.push_back(a);
      n++;
      if (n >= MAXE) begin
        exp_ovf = 1'b1;
        break;
      end
      w = mem[a[11:2]];
      if (w[31] == 1'b0) begin
        pa = {8'h0, pb} + {11'h0, w[20:0]} * 32'd4;
        exp_rend.push_back({pa[23:0], 2'd0, w[24], w[23:21], w[30:25]});
        a = a + 24'd4;
      end else if (w[30] == 1'b0) begin
        cnt    = int'(w[28:25]) + 1;
        vw     = 3 + int'(w[23:21]);
        stride = w[29] ? 4 * (3 + 4 * vw) : 4 * (3 + 3 * vw);
        for (int i = 0; i < cnt; i++) begin
          pa = {8'h0, pb} + {11'h0, w[20:0]} * 32'd4 + 32'(i * stride);
          exp_rend.push_back({pa[23:0], (w[29] ? 2'd2 : 2'd1), w[24], w[23:21], 6'd0});
        end
        a = a + 24'd4;
      end else if (w[29] == 1'b0) begin
        a = a + 24'd4;
      end else if (w[28]) begin
        break;
      end else begin
        a = {w[23:2], 2'b00};
      end
    end
  endtask

  task automatic gen_list(input logic [23:0] base);
    logic [23:0] a, nxt;
    logic [31:0] rnd;
    int r;
    a = base & 24'hFF_FFFC;
    for (int k = 0; k < 5; k++) begin
      r   = int'($urandom_range(0, 9));
      rnd = $urandom;
      if (r == 9) begin
        mem[a[11:2]] = {3'b111, 1'b1, rnd[27:0]};
        return;
      end else if (r == 8) begin
        nxt = a + 24'(4 * $urandom_range(1, 8));
        mem[a[11:2]] = {3'b111, 1'b0, rnd[27:24], nxt[23:2], rnd[1:0]};
        a = nxt;
      end else begin
        if (r <= 2)      mem[a[11:2]] = {1'b0, rnd[30:0]};
        else if (r <= 4) mem[a[11:2]] = {3'b100, rnd[28:0]};
        else if (r <= 6) mem[a[11:2]] = {3'b101, rnd[28:0]};
        else             mem[a[11:2]] = {3'b110, rnd[28:0]};
        a = a + 24'd4;
      end
    end
    mem[a[11:2]] = 32'hF000_0000;
  endtask

  vec_t vecs[6];
  logic [23:0] ra, rpb;

  initial begin
    vecs[0] = '{32'h7E00_0010, 24'h02_0000, 24'h02_0040, 2'd0, 1'b0, 3'd0, 6'h3F, 1};
    vecs[1] = '{32'h8400_0008, 24'h00_0000, 24'h00_0020, 2'd1, 1'b0, 3'd0, 6'h00, 3};
    vecs[2] = '{32'hA040_0000, 24'h00_1000, 24'h00_1000, 2'd2, 1'b0, 3'd2, 6'h00, 1};
    vecs[3] = '{32'h01FF_FFFF, 24'hFF_FFF0, 24'h7F_FFEC, 2'd0, 1'b1, 3'd7, 6'h00, 1};
    vecs[4] = '{32'hBF00_0001, 24'h00_0010, 24'h00_0014, 2'd2, 1'b1, 3'd0, 6'h00, 16};
    vecs[5] = '{32'h4A60_0003, 24'h00_0100, 24'h00_010C, 2'd0, 1'b0, 3'd3, 6'h25, 1};

    reset_n = 1'b0; start = 1'b0; ol_addr = 24'd0; param_base = 24'd0;
    drawn_man = 1'b0; auto_en = 1'b1;
    for (int i = 0; i < 1024; i++) mem[i] = 32'h0;
    tick(3);
    check("reset_outputs", 64'(|{bus.ol_vram_rd, bus.render_poly, busy, done, overflow, bus.ol_vram_addr,
          bus.poly_addr, bus.prim_type, bus.shadow, bus.skip, bus.strip_mask}), 64'd0);
    reset_n = 1'b1;
    tick(2);
    check("idle_after_release", 64'({busy, done, bus.ol_vram_rd}), 64'd0);

    // Decode table: one entry followed by an end link.
    for (int v = 0; v < 6; v++) begin
      mem[24'h100 >> 2] = vecs[v].word;
      mem[24'h104 >> 2] = 32'hF000_0000;
      clear_obs();
      do_start(24'h100, vecs[v].pbase);
      wait_done($sformatf("vec%0d", v), 0);
      check($sformatf("vec%0d_nrender", v), 64'(got_rend.size()), 64'(vecs[v].exp_n));
      if (got_rend.size() > 0)
        check($sformatf("vec%0d_first", v), 64'(got_rend[0]),
              64'({vecs[v].exp_addr, vecs[v].exp_type, vecs[v].exp_sh, vecs[v].exp_sk, vecs[v].exp_mask}));
      check($sformatf("vec%0d_nreads", v), 64'(got_rd.size()), 64'd2);
      check($sformatf("vec%0d_done_after_link", v), 64'(done_cyc), 64'(last_rd_cyc + 2));
      check($sformatf("vec%0d_ovf", v), 64'(done_ovf), 64'd0);
    end

    // Triangle array: three primitives at a 48-byte stride.
    mem[24'h100 >> 2] = 32'h8400_0008;
    clear_obs();
    do_start(24'h100, 24'h0);
    wait_done("tri", 0);
    if (got_rend.size() == 3) begin
      check("tri_addr0", 64'(got_rend[0].addr), 64'h20);
      check("tri_addr1", 64'(got_rend[1].addr), 64'h50);
      check("tri_addr2", 64'(got_rend[2].addr), 64'h80);
    end else check("tri_count", 64'(got_rend.size()), 64'd3);

    // Quad held in WAIT_DRAWN; a poly_drawn during ISSUE must not count.
    auto_en = 1'b0;
    mem[24'h100 >> 2] = 32'hA040_0000;
    clear_obs();
    do_start(24'h100, 24'h0);
    wait_render("quad", 1);
    drawn_man = 1'b1;
    @(negedge clock);
    drawn_man = 1'b0;
    tick(50);
    check("quad_hold_reads", 64'(got_rd.size()), 64'd1);
    check("quad_hold_renders", 64'(got_rend.size()), 64'd1);
    check("quad_hold_busy", 64'({busy, done}), 64'b10);
    check("quad_attrs", 64'({bus.prim_type, bus.skip}), 64'({2'd2, 3'd2}));
    drawn_man = 1'b1;
    @(negedge clock);
    drawn_man = 1'b0;
    auto_en = 1'b1;
    wait_done("quad", 0);
    check("quad_reads", 64'(got_rd.size()), 64'd2);

    // Link hop: 0x100 -> 0x200 strip -> 0x204 end.
    mem[24'h100 >> 2] = 32'hE000_0200;
    mem[24'h200 >> 2] = 32'h0000_0001;
    mem[24'h204 >> 2] = 32'hF000_0000;
    clear_obs();
    do_start(24'h100, 24'h0);
    wait_done("link", 0);
    if (got_rd.size() == 3)
      check("link_reads", 64'({got_rd[0], got_rd[1], got_rd[2]}), 64'({24'h100, 24'h200, 24'h204}));
    else check("link_nreads", 64'(got_rd.size()), 64'd3);
    check("link_nrender", 64'(got_rend.size()), 64'd1);

    // Overflow on a run of reserved words, then cleared by the next start.
    for (int i = 0; i < 8; i++) mem[(24'h300 >> 2) + i] = 32'hC000_0000;
    clear_obs();
    do_start(24'h300, 24'h0);
    wait_done("ovf", 0);
    check("ovf_nreads", 64'(got_rd.size()), 64'd4);
    if (got_rd.size() == 4) check("ovf_last_read", 64'(got_rd[3]), 64'h30C);
    check("ovf_flag", 64'({done_ovf, overflow}), 64'b11);
    check("ovf_nrender", 64'(got_rend.size()), 64'd0);
    mem[24'h100 >> 2] = 32'h0000_0000;
    mem[24'h104 >> 2] = 32'hF000_0000;
    clear_obs();
    do_start(24'h100, 24'h0);
    check("ovf_cleared", 64'({overflow, busy}), 64'b01);
    wait_done("ovf_next", 0);

    // Asynchronous reset in WAIT_DRAWN abandons the walk.
    auto_en = 1'b0;
    mem[24'h100 >> 2] = 32'h8400_0008;
    clear_obs();
    do_start(24'h100, 24'h0);
    wait_render("rst", 1);
    tick(2);
    #2 reset_n = 1'b0;
    #1 check("async_reset", 64'(|{bus.ol_vram_rd, bus.render_poly, busy, done, overflow, bus.ol_vram_addr,
             bus.poly_addr, bus.prim_type, bus.shadow, bus.skip, bus.strip_mask}), 64'd0);
    tick(3);
    reset_n = 1'b1;
    auto_en = 1'b1;
    clear_obs();
    tick(6);
    check("rst_quiet", 64'(got_rd.size() + got_rend.size() + done_cnt), 64'd0);
    mem[24'h400 >> 2] = 32'h0000_0002;
    mem[24'h404 >> 2] = 32'hF000_0000;
    do_start(24'h400, 24'h0);
    wait_done("rst_new", 0);
    if (got_rd.size() > 0) check("rst_new_first_read", 64'(got_rd[0]), 64'h400);
    else check("rst_new_nreads", 64'(got_rd.size()), 64'd2);
    check("rst_new_nrender", 64'(got_rend.size()), 64'd1);

    // Random lists against the reference walk.
    for (int it = 0; it < 40; it++) begin
      ra  = 24'($urandom);
      rpb = 24'($urandom);
      gen_list(ra);
      model_walk(ra, rpb);
      clear_obs();
      do_start(ra, rpb);
      wait_done($sformatf("rnd%0d", it), int'($urandom_range(1, 20)));
      check($sformatf("rnd%0d_nreads", it), 64'(got_rd.size()), 64'(exp_rd.size()));
      for (int k = 0; k < exp_rd.size() && k < got_rd.size(); k++)
        check($sformatf("rnd%0d_read%0d", it, k), 64'(got_rd[k]), 64'(exp_rd[k]));
      check($sformatf("rnd%0d_nrender", it), 64'(got_rend.size()), 64'(exp_rend.size()));
      for (int k = 0; k < exp_rend.size() && k < got_rend.size(); k++)
        check($sformatf("rnd%0d_render%0d", it, k), 64'(got_rend[k]), 64'(exp_rend[k]));
      check($sformatf("rnd%0d_done", it), 64'({28'd0, done_cnt[3:0], done_ovf, overflow, busy}),
            64'({28'd0, 4'd1, exp_ovf, exp_ovf, 1'b0}));
    end

    check("one_outstanding", 64'(viol), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
